// File: rtl/a2d_rr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ==== a2d_rr_sched : round-robin lft/rght/batt A2D sequencer over a shared SPI monarch ====
// ==== optional done-timeout abort when A2D_TIMEOUT_EN is defined            rev 1.0 ====
module a2d_rr_sched #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5,
    parameter int         TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        a2d_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_WAIT1 = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_WAIT2 = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] batt_q, batt_d;
    logic        cmplt_q, cmplt_d;
    logic        w_tmo;
    logic [2:0]  w_ch;
    logic [1:0]  w_ptr_inc;
    logic        w_unused_rd_hi;

    // The upper nibble of the A2D response carries no conversion data.
    assign w_unused_rd_hi = &{1'b0, rd_data[15:12]};

    always_comb begin
        case (ptr_q)
            2'd0:    w_ch = LFT_CH;
            2'd1:    w_ch = RGHT_CH;
            default: w_ch = BATT_CH;
        endcase
    end

    assign w_ptr_inc = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        cmplt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (nxt) begin
                    state_d = S_CMD;
                    wrt_d   = 1'b1;
                    cmd_d   = {2'b00, w_ch, 11'h000};
                end
            end
            S_CMD:   state_d = S_WAIT1;
            S_WAIT1: begin
                if (done) begin
                    state_d = S_GAP;
                end else if (w_tmo) begin
                    state_d = S_IDLE;
                    ptr_d   = w_ptr_inc;
                end
            end
            S_GAP: begin
                state_d = S_RD;
                wrt_d   = 1'b1;
            end
            S_RD:    state_d = S_WAIT2;
            S_WAIT2: begin
                if (done) begin
                    state_d = S_IDLE;
                    ptr_d   = w_ptr_inc;
                    cmplt_d = 1'b1;
                    case (ptr_q)
                        2'd0:    lft_d  = rd_data[11:0];
                        2'd1:    rght_d = rd_data[11:0];
                        default: batt_d = rd_data[11:0];
                    endcase
                end else if (w_tmo) begin
                    state_d = S_IDLE;
                    ptr_d   = w_ptr_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Battery resets to full scale so a low-battery compare stays quiet until measured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'hFFF;
            cmplt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
            cmplt_q <= cmplt_d;
        end
    end

`ifdef A2D_TIMEOUT_EN
    localparam int            TW         = $clog2(TMO_CYC) + 1;
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          w_waiting;

    // Counter is zero in CMD/RD, so it starts cleared on every WAIT entry.
    assign w_waiting = (state_q == S_WAIT1) || (state_q == S_WAIT2);
    assign w_tmo     = w_waiting && (tmo_q == C_TMO_LAST);

    always_comb begin
        tmo_d = w_waiting ? tmo_q + TW'(1) : '0;
        err_d = w_tmo && !done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign a2d_err = err_q;
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = TMO_CYC;
    assign w_tmo        = 1'b0;
    assign a2d_err      = 1'b0;
`endif

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cmplt_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_rr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_a2d_rr_sched : randomized scoreboard bench with an SPI responder model ====
// ==== rev 1.0 ====
module tb_a2d_rr_sched;

    localparam int TMO = 16;

    typedef struct {
        int          nxt_cyc;
        int          ch;
        logic [15:0] cmd;
    } conv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, a2d_err;

    a2d_rr_sched #(
        .LFT_CH (3'd0),
        .RGHT_CH(3'd4),
        .BATT_CH(3'd5),
        .TMO_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .nxt      (nxt),
        .wrt      (wrt),
        .cmd      (cmd),
        .done     (done),
        .rd_data  (rd_data),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .batt     (batt),
        .cnv_cmplt(cnv_cmplt),
        .a2d_err  (a2d_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel number for rotation slot 0/1/2 (lft, rght, batt).
    function automatic int chan_of(input int slot);
        case (slot)
            0:       return 0;
            1:       return 4;
            default: return 5;
        endcase
    endfunction

    conv_t       conv_q[$];
    int          acc_tot = 0, acc_cnt = 0, stim_fail = 0;
    logic [1:0]  spi_hold = 2'b00;
    bit          final_req = 1'b0;

    int          checks = 0, errors = 0;
    int          phase = 0, cnt = 0, exp2 = 0, last_wrt = 0, exp_c = 0;
    int          pend_ch = 0, fin_tot = 0, fin_cyc = 0, n_read = 0, stim_fail_seen = 0;
    bit          pend = 1'b0, final_ack = 1'b0;
    logic [11:0] pend_val = 12'h000;
    logic [11:0] m_reg [3] = '{12'h000, 12'h000, 12'hFFF};
    logic [15:0] preset [3] = '{16'hF123, 16'h0456, 16'h0789};
    conv_t       cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor, scoreboard and SPI responder; samples outputs on the falling edge.
    always @(negedge clk) begin
        logic [15:0] v;
        if (cyc > 0) begin
            if (rst) begin
                chk("rst_wrt", 32'(wrt), 32'd0);
                chk("rst_cmd", 32'(cmd), 32'd0);
                chk("rst_lft", 32'(lft_ld), 32'd0);
                chk("rst_rght", 32'(rght_ld), 32'd0);
                chk("rst_batt", 32'(batt), 32'hFFF);
                chk("rst_cnv_cmplt", 32'(cnv_cmplt), 32'd0);
                chk("rst_a2d_err", 32'(a2d_err), 32'd0);
                phase = 0; cnt = 0; pend = 1'b0;
                conv_q.delete();
                m_reg[0] = 12'h000; m_reg[1] = 12'h000; m_reg[2] = 12'hFFF;
                fin_tot = acc_tot; fin_cyc = cyc;
                done = 1'b0;
                rd_data = 16'($urandom);
            end else begin
                if (pend && cyc == exp_c) begin
                    chk("cnv_cmplt", 32'(cnv_cmplt), 32'd1);
                    m_reg[pend_ch] = pend_val;
                    pend = 1'b0;
                end else if (cnv_cmplt) begin
                    chk("cnv_cmplt_spurious", 32'(cnv_cmplt), 32'd0);
                end
                chk("lft_ld", 32'(lft_ld), 32'(m_reg[0]));
                chk("rght_ld", 32'(rght_ld), 32'(m_reg[1]));
                chk("batt", 32'(batt), 32'(m_reg[2]));

                if (a2d_err) begin
`ifdef A2D_TIMEOUT_EN
                    chk("a2d_err_delay", 32'(cyc - last_wrt), 32'(TMO + 1));
                    chk("a2d_err_phase", 32'(phase == 1 || phase == 3), 32'd1);
`else
                    chk("a2d_err", 32'(a2d_err), 32'd0);
`endif
                    phase = 0; cnt = 0;
                    fin_tot++; fin_cyc = cyc - 1;
                end
`ifdef A2D_TIMEOUT_EN
                else if ((phase == 1 || phase == 3) && cnt == 0 && cyc > last_wrt + TMO + 1) begin
                    chk("a2d_err_missing", 32'(a2d_err), 32'd1);
                    phase = 0; fin_tot++; fin_cyc = cyc;
                end
`endif

                if (wrt) begin
                    if (phase == 0 && conv_q.size() > 0) begin
                        cur = conv_q.pop_front();
                        chk("cmd1", 32'(cmd), 32'(cur.cmd));
                        chk("wrt1_cycle", 32'(cyc), 32'(cur.nxt_cyc + 1));
                        phase = 1; last_wrt = cyc;
                        cnt = spi_hold[0] ? 0 : int'($urandom_range(2, 6));
                    end else if (phase == 2) begin
                        chk("cmd2", 32'(cmd), 32'(cur.cmd));
                        chk("wrt2_cycle", 32'(cyc), 32'(exp2));
                        phase = 3; last_wrt = cyc;
                        cnt = spi_hold[1] ? 0 : int'($urandom_range(2, 6));
                    end else begin
                        chk("wrt_spurious", 32'(wrt), 32'd0);
                    end
                end else begin
                    if (phase == 0 && conv_q.size() > 0 && cyc > conv_q[0].nxt_cyc + 1) begin
                        chk("wrt1_missing", 32'(wrt), 32'd1);
                        void'(conv_q.pop_front());
                        fin_tot++; fin_cyc = cyc;
                    end
                    if (phase == 2 && cyc >= exp2) begin
                        chk("wrt2_missing", 32'(wrt), 32'd1);
                        phase = 0; fin_tot++; fin_cyc = cyc;
                    end
                    if (phase != 0)
                        chk("cmd_hold", 32'(cmd), 32'(cur.cmd));
                end

                if (final_req && !final_ack) begin
                    chk("queue_empty", 32'(conv_q.size()), 32'd0);
                    chk("result_pending", 32'(pend), 32'd0);
                    final_ack = 1'b1;
                end
                if (stim_fail != stim_fail_seen) begin
                    chk("stim_wait_bound", 32'(stim_fail), 32'(stim_fail_seen));
                    stim_fail_seen = stim_fail;
                end

                // SPI responder: drive done/rd_data for the next rising edge.
                done = 1'b0;
                rd_data = 16'($urandom);
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        done = 1'b1;
                        if (phase == 1) begin
                            phase = 2; exp2 = cyc + 2;
                        end else if (phase == 3) begin
                            v = (n_read < 3) ? preset[n_read] : 16'($urandom);
                            n_read++;
                            rd_data = v;
                            pend = 1'b1; pend_ch = cur.ch; pend_val = v[11:0]; exp_c = cyc + 1;
                            phase = 0; fin_tot++; fin_cyc = cyc;
                        end
                    end
                end else if (phase == 0 && conv_q.size() == 0 && $urandom_range(0, 5) == 0) begin
                    done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit is_idle();
        return (fin_tot == acc_tot) && (cyc > fin_cyc);
    endfunction

    task automatic issue();
        conv_t c;
        c.nxt_cyc = cyc;
        c.ch      = acc_cnt % 3;
        c.cmd     = 16'(chan_of(c.ch) * 2048);
        conv_q.push_back(c);
        nxt = 1'b1;
        acc_cnt++;
        acc_tot++;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            nxt = 1'b0;
            n++;
        end while (!is_idle() && n < 500);
        if (n >= 500) stim_fail++;
    endtask

    // Random traffic; nxt while busy (incl. coincident with the final done) must be dropped.
    task automatic random_phase(input int n_conv);
        int target = acc_tot + n_conv;
        int guard  = 0;
        while (acc_tot < target && guard < 8000) begin
            tick();
            guard++;
            nxt = 1'b0;
            if (is_idle()) begin
                if ($urandom_range(0, 2) == 0) issue();
            end else if (cyc == fin_cyc || $urandom_range(0, 3) == 0) begin
                nxt = 1'b1;
            end
        end
        if (guard >= 8000) stim_fail++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        acc_cnt = 0;
        repeat (10) tick();

        random_phase(40);

        // Reset while the read-back transaction is outstanding.
        wait_idle();
        spi_hold = 2'b10;
        issue();
        n = 0;
        do begin
            tick();
            nxt = 1'b0;
            n++;
        end while (phase != 3 && n < 100);
        if (n >= 100) stim_fail++;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_cnt = 0;
        spi_hold = 2'b00;

`ifdef A2D_TIMEOUT_EN
        wait_idle();
        spi_hold = 2'b01;
        issue();
        wait_idle();
        spi_hold = 2'b00;
`endif
        wait_idle();
        issue();
        wait_idle();

        random_phase(20);
        wait_idle();
        repeat (5) tick();
        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_ack; i++) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
